// File: rtl/gtech_bist_pkg.sv
// Shared types, defaults and the MISR step function for the GTECH cell BIST.
package gtech_bist_pkg;

    localparam int unsigned MAX_W = 32;

    localparam logic [15:0] DEF_POLY   = 16'h1021;
    localparam logic [15:0] DEF_SEED   = 16'hFFFF;
    localparam logic [15:0] DEF_GOLDEN = 16'h0E11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // One MISR shift: shift left, fold in POLY when the MSB falls off, XOR in the response.
    // Operands are carried at MAX_W and masked down to the live width.
    function automatic logic [MAX_W-1:0] misr_step(
        input logic [MAX_W-1:0] sig,
        input logic [MAX_W-1:0] resp,
        input logic [MAX_W-1:0] poly,
        input int unsigned      width
    );
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] nxt;
        logic             msb;
        mask = (width >= MAX_W) ? '1 : ((MAX_W'(1) << width) - MAX_W'(1));
        msb  = |((sig >> (width - 1)) & MAX_W'(1));
        nxt  = (sig << 1) ^ (msb ? poly : '0) ^ resp;
        return nxt & mask;
    endfunction

endpackage

// File: rtl/gtech_misr.sv
// Multiple-input signature register compacting the cell-under-test response.
module gtech_misr
    import gtech_bist_pkg::*;
#(
    parameter int unsigned      SIG_W = 16,
    parameter int unsigned      N_OUT = 1,
    parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEF_SEED)
) (
    input  logic             CP,
    input  logic             CD,
    input  logic             CLR,
    input  logic             EN,
    input  logic [N_OUT-1:0] RESP,
    output logic [SIG_W-1:0] SIG
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_sig_next;

    assign w_sig_next = SIG_W'(misr_step(MAX_W'(r_sig), MAX_W'(RESP), MAX_W'(POLY), SIG_W));

    // Signature register: seed on reset or clear, advance one step per enabled cycle.
    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_sig <= SEED;
        end else if (CLR) begin
            r_sig <= SEED;
        end else if (EN) begin
            r_sig <= w_sig_next;
        end
    end

    assign SIG = r_sig;

endmodule

// File: rtl/gtech_cell_bist.sv
// Exhaustive-pattern BIST harness for a single GTECH combinational cell.
module gtech_cell_bist
    import gtech_bist_pkg::*;
#(
    parameter int unsigned      N_IN   = 2,
    parameter int unsigned      N_OUT  = 1,
    parameter int unsigned      SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY   = SIG_W'(DEF_POLY),
    parameter logic [SIG_W-1:0] SEED   = SIG_W'(DEF_SEED),
    parameter logic [SIG_W-1:0] GOLDEN = SIG_W'(DEF_GOLDEN)
) (
    input  logic             CP,
    input  logic             CD,
    input  logic             START,
    output logic [N_IN-1:0]  STIM,
    input  logic [N_OUT-1:0] RESP,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [SIG_W-1:0] SIG
);

    localparam int unsigned     CNT_W    = N_IN + 1;
    localparam logic [CNT_W-1:0] LAST_PAT = CNT_W'((1 << N_IN) - 1);

    state_e           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [N_IN-1:0]  r_stim;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;

    logic             w_clr;
    logic             w_en;
    logic [SIG_W-1:0] w_sig;
    logic [SIG_W-1:0] w_sig_next;

    // A new run may only be launched from IDLE or DONE; the MISR advances only in RUN.
    assign w_clr = START && (r_state != S_RUN);
    assign w_en  = (r_state == S_RUN);

    // Signature the MISR will hold after this edge, needed to grade the final capture.
    assign w_sig_next = SIG_W'(misr_step(MAX_W'(w_sig), MAX_W'(RESP), MAX_W'(POLY), SIG_W));

    gtech_misr #(
        .SIG_W (SIG_W),
        .N_OUT (N_OUT),
        .POLY  (POLY),
        .SEED  (SEED)
    ) u_misr (
        .CP   (CP),
        .CD   (CD),
        .CLR  (w_clr),
        .EN   (w_en),
        .RESP (RESP),
        .SIG  (w_sig)
    );

    // Sequencer: launch, walk all 2^N_IN patterns, then grade and hold the verdict.
    always_ff @(posedge CP or negedge CD) begin
        if (!CD) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_stim  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_stim  <= '0;
                        r_busy  <= 1'b1;
                        r_done  <= 1'b0;
                        r_pass  <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_stim <= r_stim + N_IN'(1);
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_PAT) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= (w_sig_next == GOLDEN);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign STIM = r_stim;
    assign BUSY = r_busy;
    assign DONE = r_done;
    assign PASS = r_pass;
    assign SIG  = w_sig;

endmodule

// File: tb/tb_gtech_cell_bist.sv
// Scoreboard bench for gtech_cell_bist: NAND2-sized instance plus a 3-in/2-out instance.
module tb_gtech_cell_bist;
    import gtech_bist_pkg::*;

    localparam logic [15:0] TT2_GOLD = 16'hB4E1;

    // Golden signature for the 3-in/2-out table, built with the shared step function.
    function automatic logic [15:0] golden_of(input logic [15:0] t);
        logic [15:0] s;
        s = DEF_SEED;
        for (int i = 0; i < 8; i++)
            s = 16'(misr_step(32'(s), 32'((t >> (2 * i)) & 16'h3), 32'(DEF_POLY), 16));
        return s;
    endfunction

    localparam logic [15:0] GOLDEN2 = golden_of(TT2_GOLD);

    // Reference MISR as polynomial arithmetic: multiply by x, reduce by x^16+x^12+x^5+1.
    function automatic logic [15:0] ref_next(input logic [15:0] s, input logic [15:0] r);
        logic [16:0] w;
        w = {s, 1'b0};
        if (w[16]) w = w ^ 17'h11021;
        return w[15:0] ^ r;
    endfunction

    typedef struct packed {
        logic [15:0] sig;
        logic        pass;
    } fin_t;

    logic CP;
    logic CD;

    logic        start1, busy1, done1, pass1, resp1;
    logic [1:0]  stim1;
    logic [15:0] sig1;
    logic [3:0]  tt1;

    logic        start2, busy2, done2, pass2;
    logic [2:0]  stim2;
    logic [1:0]  resp2;
    logic [15:0] sig2;
    logic [15:0] tt2;

    assign resp1 = tt1[stim1];
    assign resp2 = tt2[2 * stim2 +: 2];

    gtech_cell_bist u_dut1 (
        .CP(CP), .CD(CD), .START(start1), .STIM(stim1), .RESP(resp1),
        .BUSY(busy1), .DONE(done1), .PASS(pass1), .SIG(sig1)
    );

    gtech_cell_bist #(.N_IN(3), .N_OUT(2), .SIG_W(16), .GOLDEN(GOLDEN2)) u_dut2 (
        .CP(CP), .CD(CD), .START(start2), .STIM(stim2), .RESP(resp2),
        .BUSY(busy2), .DONE(done2), .PASS(pass2), .SIG(sig2)
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int n_pass = 0;
    int n_tot  = 0;

    logic [15:0] exp_steps1[$];
    fin_t        exp_fin1[$];
    fin_t        exp_fin2[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Monitor for instance 1: per-step signature, run length and final verdict.
    logic pb1 = 1'b0;
    logic pd1 = 1'b0;
    int   run_len1 = 0;
    fin_t f1;
    always @(negedge CP) begin
        if (busy1 && !pb1) run_len1 = 1;
        else if (busy1) run_len1++;
        chk("pass1_outside_done", 32'(pass1 && !done1), 32'(0));
        if ((busy1 && pb1) || (done1 && !pd1)) begin
            chk("step1_pending", 32'(exp_steps1.size() != 0), 32'(1));
            if (exp_steps1.size() != 0) chk("sig1_step", 32'(sig1), 32'(exp_steps1.pop_front()));
        end
        if (done1 && !pd1) begin
            chk("fin1_pending", 32'(exp_fin1.size() != 0), 32'(1));
            if (exp_fin1.size() != 0) begin
                f1 = exp_fin1.pop_front();
                chk("sig1_final", 32'(sig1), 32'(f1.sig));
                chk("pass1", 32'(pass1), 32'(f1.pass));
                chk("stim1_wrapped", 32'(stim1), 32'(0));
                chk("run1_cycles", 32'(run_len1), 32'(4));
            end
        end
        pb1 = busy1;
        pd1 = done1;
    end

    // Monitor for instance 2: final verdict on each DONE rise.
    logic pd2 = 1'b0;
    fin_t f2;
    always @(negedge CP) begin
        chk("pass2_outside_done", 32'(pass2 && !done2), 32'(0));
        if (done2 && !pd2) begin
            chk("fin2_pending", 32'(exp_fin2.size() != 0), 32'(1));
            if (exp_fin2.size() != 0) begin
                f2 = exp_fin2.pop_front();
                chk("sig2_final", 32'(sig2), 32'(f2.sig));
                chk("pass2", 32'(pass2), 32'(f2.pass));
                chk("stim2_wrapped", 32'(stim2), 32'(0));
            end
        end
        pd2 = done2;
    end

    task automatic push_model1();
        logic [15:0] s;
        fin_t f;
        s = 16'hFFFF;
        for (int p = 0; p < 4; p++) begin
            s = ref_next(s, 16'(tt1[p]));
            exp_steps1.push_back(s);
        end
        f.sig  = s;
        f.pass = (s == 16'h0E11);
        exp_fin1.push_back(f);
    endtask

    task automatic push_model2();
        logic [15:0] s;
        fin_t f;
        s = 16'hFFFF;
        for (int p = 0; p < 8; p++) s = ref_next(s, 16'(tt2[2 * p +: 2]));
        f.sig  = s;
        f.pass = (s == GOLDEN2);
        exp_fin2.push_back(f);
    endtask

    task automatic pulse1();
        @(negedge CP); start1 = 1'b1;
        @(negedge CP); start1 = 1'b0;
        chk("busy1_after_start", 32'(busy1), 32'(1));
        chk("done1_cleared", 32'(done1), 32'(0));
    endtask

    task automatic pulse2();
        @(negedge CP); start2 = 1'b1;
        @(negedge CP); start2 = 1'b0;
        chk("busy2_after_start", 32'(busy2), 32'(1));
    endtask

    task automatic wait_done1();
        for (int i = 0; i < 20 && !done1; i++) @(negedge CP);
        chk("done1_timeout", 32'(done1), 32'(1));
    endtask

    task automatic wait_done2();
        for (int i = 0; i < 30 && !done2; i++) @(negedge CP);
        chk("done2_timeout", 32'(done2), 32'(1));
    endtask

    task automatic run2(input logic [15:0] t);
        tt2 = t;
        push_model2();
        pulse2();
        wait_done2();
    endtask

    initial begin
        fin_t lf;
        int   rises, last, cyc;
        logic pdl;

        CD = 1'b1; start1 = 1'b0; start2 = 1'b0;
        tt1 = 4'b0111; tt2 = TT2_GOLD;
        #2 CD = 1'b0;
        #1;
        chk("rst_stim1", 32'(stim1), 32'(0));
        chk("rst_sig1", 32'(sig1), 32'hFFFF);
        chk("rst_busy1", 32'(busy1), 32'(0));
        chk("rst_done1", 32'(done1), 32'(0));
        chk("rst_pass1", 32'(pass1), 32'(0));
        chk("rst_sig2", 32'(sig2), 32'hFFFF);
        @(negedge CP) CD = 1'b1;

        // Fault-free NAND2 with the documented signature trail.
        exp_steps1.push_back(16'hEFDE);
        exp_steps1.push_back(16'hCF9C);
        exp_steps1.push_back(16'h8F18);
        exp_steps1.push_back(16'h0E11);
        lf.sig = 16'h0E11; lf.pass = 1'b1;
        exp_fin1.push_back(lf);
        pulse1();
        wait_done1();
        repeat (3) @(negedge CP);
        chk("done1_hold", 32'(done1), 32'(1));
        chk("sig1_hold", 32'(sig1), 32'h0E11);

        // Restart from DONE.
        push_model1();
        pulse1();
        wait_done1();

        // START held through RUN must not disturb the sequence.
        push_model1();
        @(negedge CP); start1 = 1'b1;
        repeat (4) @(negedge CP);
        start1 = 1'b0;
        wait_done1();
        repeat (2) @(negedge CP);
        chk("no_restart_done1", 32'(done1), 32'(1));
        chk("no_restart_busy1", 32'(busy1), 32'(0));

        // Output stuck-at-1.
        tt1 = 4'b1111;
        for (int p = 0; p < 4; p++) begin
            lf.sig = (p == 0) ? ref_next(16'hFFFF, 16'h1) : ref_next(lf.sig, 16'h1);
            exp_steps1.push_back(lf.sig);
        end
        lf.sig = 16'h0E10; lf.pass = 1'b0;
        exp_fin1.push_back(lf);
        pulse1();
        wait_done1();

        // Asynchronous reset in the middle of a run.
        tt1 = 4'b0111;
        push_model1();
        pulse1();
        repeat (2) @(negedge CP);
        #2 CD = 1'b0;
        #1;
        chk("midrun_stim1", 32'(stim1), 32'(0));
        chk("midrun_sig1", 32'(sig1), 32'hFFFF);
        chk("midrun_busy1", 32'(busy1), 32'(0));
        chk("midrun_done1", 32'(done1), 32'(0));
        chk("midrun_pass1", 32'(pass1), 32'(0));
        exp_steps1.delete();
        exp_fin1.delete();
        @(negedge CP) CD = 1'b1;
        push_model1();
        pulse1();
        wait_done1();
        chk("post_reset_pass1", 32'(pass1), 32'(1));

        // Random 2-input truth tables.
        for (int k = 0; k < 4; k++) begin
            tt1 = 4'($urandom);
            push_model1();
            pulse1();
            wait_done1();
        end

        // START held high: back-to-back runs, one DONE cycle every five.
        tt1 = 4'b0111;
        repeat (3) push_model1();
        @(negedge CP); start1 = 1'b1;
        rises = 0; last = 0; cyc = 0; pdl = 1'b0;
        while (rises < 3 && cyc < 60) begin
            @(negedge CP);
            cyc++;
            if (pdl) chk("done1_width", 32'(done1), 32'(0));
            if (done1 && !pdl) begin
                rises++;
                if (rises > 1) chk("done1_period", 32'(cyc - last), 32'(5));
                last = cyc;
            end
            pdl = done1;
        end
        start1 = 1'b0;
        chk("held_rises", 32'(rises), 32'(3));

        // 3-input / 2-output CUT: golden table, every single-bit flip, random tables.
        run2(TT2_GOLD);
        chk("golden_pass2", 32'(pass2), 32'(1));
        for (int b = 0; b < 16; b++) begin
            run2(TT2_GOLD ^ (16'h1 << b));
            chk("flip_pass2", 32'(pass2), 32'(0));
        end
        for (int k = 0; k < 4; k++) run2(16'($urandom));

        repeat (3) @(negedge CP);
        chk("steps1_drained", 32'(exp_steps1.size()), 32'(0));
        chk("fin1_drained", 32'(exp_fin1.size()), 32'(0));
        chk("fin2_drained", 32'(exp_fin2.size()), 32'(0));

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
